mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access stage directly downstream of the EX/MEM pipeline register.
//  Consumes the M-stage control/data bundle, performs word load/store on an
//  internal data RAM with fixed multi-cycle latency, and drives the MEM/WB
//  register outputs for the write-back stage.
//  Raises mstall while an access is pending so the hazard unit freezes PC..EX/MEM.
// PARAMETERS
//  DEPTH    256  data RAM size in 32-bit words (power of 2)
//  ADDR_W   8    log2(DEPTH); word index = mr[ADDR_W+1:2]
//  MEM_LAT  2    RAM access latency in cycles (legal range >= 1)
// PORTS
//  clock     in   1   rising-edge clock
//  clrn      in   1   asynchronous active-low reset
//  mwreg     in   1   M-stage register-write enable
//  mm2reg    in   1   M-stage load (result from memory)
//  mwmem     in   1   M-stage store
//  mdestReg  in   5   M-stage destination register
//  mr        in   32  ALU result / byte address
//  mqb       in   32  store data
//  mstall    out  1   1 = hold upstream stages this cycle (combinational)
//  wwreg     out  1   W-stage register-write enable
//  wm2reg    out  1   W-stage select memory data
//  wdestReg  out  5   W-stage destination register
//  wr        out  32  W-stage ALU result (captured mr)
//  wdo       out  32  W-stage load data (0 when not a load)
// BEHAVIOUR
//  - clrn=0 (async): state=IDLE, cnt=0, capture regs=0, all outputs 0
//    (mstall=0). RAM contents NOT reset; a pending store is discarded.
//  - memop = mm2reg | mwmem. mm2reg&mwmem both 1: treated as load, no write.
//  - IDLE, memop=0: next edge wwreg<=mwreg, wm2reg<=0, wdestReg<=mdestReg,
//    wr<=mr, wdo<=0. Latency 1 edge, mstall=0, state stays IDLE.
//  - IDLE, memop=1: mstall=1. Next edge: capture mwreg,mm2reg,mwmem,mdestReg,
//    mr,mqb; cnt<=MEM_LAT-1; state<=BUSY; W outputs loaded with a bubble
//    (wwreg=0, wm2reg=0, wdestReg=0, wr=0, wdo=0).
//  - BUSY, cnt!=0: mstall=1; cnt<=cnt-1; W outputs hold bubble; M inputs ignored.
//  - BUSY, cnt==0: mstall=0 (upstream advances on this edge). Next edge:
//    store -> RAM[idx]<=captured mqb; load -> wdo<=RAM[idx] (pre-edge contents);
//    wwreg/wm2reg/wdestReg/wr <= captured values; state<=IDLE.
//  - Memory op occupies MEM_LAT+1 cycles; result appears MEM_LAT+1 edges after
//    first presentation. Back-to-back memops: each waits its own full sequence.
//  - Address: mr[1:0] ignored (no misalign trap); bits above ADDR_W+1 ignored,
//    index wraps modulo DEPTH.
//  - Store followed by load to same word: store completes first; load returns
//    the new data.
//  - Reset asserted in BUSY: returns to IDLE immediately, no RAM write, no W update.
//  - Store with mwreg=1 (illegal decode): wwreg follows captured mwreg, wdo=0.
// TESTING
//  1 Reset: clrn=0 mid-stream -> all outputs 0, mstall=0 asynchronously.
//  2 ALU op: mwreg=1,mdestReg=5,mr=0x1234 -> one edge later wwreg=1,
//    wdestReg=5,wr=0x1234,wdo=0; mstall never 1.
//  3 Store then load (MEM_LAT=2): sw mr=0x40,mqb=0xDEADBEEF -> mstall=1 for
//    2 cycles; then lw mr=0x40,mdestReg=8 -> after 3 edges wm2reg=1,
//    wdestReg=8,wdo=0xDEADBEEF.
//  4 Wrap: store 0xA5A5A5A5 at mr=0x400 (DEPTH=256) -> load mr=0x0 returns
//    0xA5A5A5A5; load mr=0x43 returns word at 0x40.
//  5 Reset mid-store: sw mr=0x80,mqb=0x11111111, pulse clrn low during BUSY
//    -> load mr=0x80 returns prior contents, not 0x11111111.
//  6 MEM_LAT=1 variant: lw -> mstall high exactly 1 cycle, result after 2 edges.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: word load/store on an internal data RAM with fixed access latency.
// Holds upstream via mstall while an access is in flight, then drives the W-stage registers.
module mem_wb_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [4:0]  mdestReg,
  input  logic [31:0] mr,
  input  logic [31:0] mqb,
  output logic        mstall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wdestReg,
  output logic [31:0] wr,
  output logic [31:0] wdo
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic        cap_wreg_reg, cap_wreg_next;
  logic        cap_m2reg_reg, cap_m2reg_next;
  logic        cap_wmem_reg, cap_wmem_next;
  logic [4:0]  cap_dest_reg, cap_dest_next;
  logic [31:0] cap_r_reg, cap_r_next;
  logic [31:0] cap_qb_reg, cap_qb_next;

  logic        wwreg_next, wm2reg_next;
  logic [4:0]  wdest_next;
  logic [31:0] wr_next, wdo_next;

  logic [31:0]       ram [DEPTH];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] rd_idx;
  logic              ram_we;
  logic              memop;
  logic              last_cycle;

  // Byte-offset bits and address bits above the RAM index are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mr[31:ADDR_W+2], mr[1:0], cap_r_reg[31:ADDR_W+2], cap_r_reg[1:0]};

  assign memop      = mm2reg | mwmem;
  assign last_cycle = (state_reg == BUSY) && (cnt_reg == '0);

  // Read address follows the incoming op while idle so the RAM output is valid from the
  // capture edge onward, which keeps MEM_LAT=1 correct.
  assign rd_idx = (state_reg == BUSY) ? cap_r_reg[ADDR_W+1:2] : mr[ADDR_W+1:2];
  assign ram_we = last_cycle && cap_wmem_reg && !cap_m2reg_reg;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[cap_r_reg[ADDR_W+1:2]] <= cap_qb_reg;
    end
    ram_q <= ram[rd_idx];
  end

  always_comb begin
    mstall = 1'b0;
    if (clrn) begin
      if (state_reg == IDLE) begin
        mstall = memop;
      end else begin
        mstall = (cnt_reg != '0);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cap_wreg_next  = cap_wreg_reg;
    cap_m2reg_next = cap_m2reg_reg;
    cap_wmem_next  = cap_wmem_reg;
    cap_dest_next  = cap_dest_reg;
    cap_r_next     = cap_r_reg;
    cap_qb_next    = cap_qb_reg;
    wwreg_next     = wwreg;
    wm2reg_next    = wm2reg;
    wdest_next     = wdestReg;
    wr_next        = wr;
    wdo_next       = wdo;

    case (state_reg)
      IDLE: begin
        if (memop) begin
          cap_wreg_next  = mwreg;
          cap_m2reg_next = mm2reg;
          cap_wmem_next  = mwmem;
          cap_dest_next  = mdestReg;
          cap_r_next     = mr;
          cap_qb_next    = mqb;
          cnt_next       = CNT_W'(MEM_LAT - 1);
          state_next     = BUSY;
          wwreg_next     = 1'b0;
          wm2reg_next    = 1'b0;
          wdest_next     = 5'd0;
          wr_next        = 32'd0;
          wdo_next       = 32'd0;
        end else begin
          wwreg_next  = mwreg;
          wm2reg_next = 1'b0;
          wdest_next  = mdestReg;
          wr_next     = mr;
          wdo_next    = 32'd0;
        end
      end
      BUSY: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          wwreg_next  = cap_wreg_reg;
          wm2reg_next = cap_m2reg_reg;
          wdest_next  = cap_dest_reg;
          wr_next     = cap_r_reg;
          wdo_next    = cap_m2reg_reg ? ram_q : 32'd0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cap_wreg_reg  <= 1'b0;
      cap_m2reg_reg <= 1'b0;
      cap_wmem_reg  <= 1'b0;
      cap_dest_reg  <= 5'd0;
      cap_r_reg     <= 32'd0;
      cap_qb_reg    <= 32'd0;
      wwreg         <= 1'b0;
      wm2reg        <= 1'b0;
      wdestReg      <= 5'd0;
      wr            <= 32'd0;
      wdo           <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cap_wreg_reg  <= cap_wreg_next;
      cap_m2reg_reg <= cap_m2reg_next;
      cap_wmem_reg  <= cap_wmem_next;
      cap_dest_reg  <= cap_dest_next;
      cap_r_reg     <= cap_r_next;
      cap_qb_reg    <= cap_qb_next;
      wwreg         <= wwreg_next;
      wm2reg        <= wm2reg_next;
      wdestReg      <= wdest_next;
      wr            <= wr_next;
      wdo           <= wdo_next;
    end
  end

endmodule
